mine_placer: RTL and testbench
==============================

Name: mine_placer

Overview:
- Parametrised successor to the fixed 8-LFSR mine generator.
- Places exactly NUM_MINES distinct mines on a COLS x ROWS board from a single LFSR, with rejection of duplicates, out-of-range cells and an optional first-click safe zone.
- Sits between the control FSM and the datapath; mine_map drives the datapath mine-map load input (MMin).

Parameters:
- COLS, 8, board columns (2..32).
- ROWS, 8, board rows (2..32).
- NUM_MINES, 10, mines to place; must be <= COLS*ROWS - 9.
- LFSR_W, 16, LFSR width; must be >= CW+RW+1.
- TAPS, 16'hB400, Galois feedback mask (maximal-length for 16 bits).
- SEED, 16'hACE1, LFSR reset value; nonzero.
- MAX_DRAWS, 4096, draw-cycle watchdog limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin placement; sampled in IDLE only.
- seed_load  in  1  load seed into LFSR this cycle.
- seed  in  LFSR_W  seed value.
- safe_en  in  1  enable safe zone.
- safe_row  in  RW  safe cell row; RW = clog2(ROWS).
- safe_col  in  CW  safe cell column; CW = clog2(COLS).
- busy  out  1  placement in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  watchdog expired; sticky until next start or reset.
- mine_map  out  COLS*ROWS  bit r*COLS+c is set for a mine at row r, column c.
- mine_count  out  clog2(COLS*ROWS+1)  mines placed so far.

Behaviour:
Reset:
- Applied at the clk edge where reset=1; overrides all other inputs.
- Result: state=IDLE, lfsr=SEED, mine_map=0, mine_count=0, busy=0, done=0, error=0, draw counter=0.

LFSR:
- Galois shift: lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- Advances every cycle in every state, so idle time adds entropy.
- seed_load overrides the advance. Loading seed==0 loads 1 instead (lock-up guard).

States:
- IDLE: busy=0. On start: mine_map<=0, mine_count<=0, error<=0, draw counter<=0, latch safe_en/safe_row/safe_col, go to DRAW. Next cycle busy=1.
- DRAW: one candidate evaluated per cycle from the current lfsr.
  - cand_col = lfsr[CW-1:0]; cand_row = lfsr[CW+RW-1:CW].
  - Reject if cand_col>=COLS or cand_row>=ROWS.
  - Reject if the mine_map bit is already set.
  - Reject if latched safe_en and |cand_row-safe_row|<=1 and |cand_col-safe_col|<=1. This is the 3x3 zone, clipped at board edges.
  - Otherwise set the bit and increment mine_count at this edge.
  - Draw counter increments every DRAW cycle.
  - Go to DONE at the edge that places mine number NUM_MINES.
  - Go to DONE immediately if mine_count==NUM_MINES on entry (NUM_MINES=0 case).
  - If the draw counter reaches MAX_DRAWS first: error<=1, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.

Other rules:
- mine_map and mine_count hold their values in IDLE/DONE; they are partial during DRAW.
- start is ignored outside IDLE.
- start and seed_load in the same cycle: seed_load applies, and draws begin from the loaded seed.
- Reset mid-DRAW: placement is aborted, and no done pulse is produced.
- Index arithmetic: r*COLS+c uses a constant multiply; no division anywhere.

Decomposition:
- Package mine_pkg: clog2 function, default TAPS/SEED constants, state encoding localparams (IDLE, DRAW, DONE).
- Sub-module mine_lfsr (parametrised LFSR_W, TAPS, SEED; ports clk, reset, seed_load, seed, q). It replaces the fixed 6-bit lfsr.
- The safe-zone compare stays inline.

Test Plan:
1. Assert reset 2 cycles -> mine_map=0, mine_count=0, busy=0, done=0, error=0. Hold IDLE 20 cycles -> outputs unchanged.
2. Defaults, safe_en=0, start pulse:
   - busy=1 the next cycle.
   - done high exactly one cycle within 4096 cycles.
   - popcount(mine_map)=10, mine_count=10.
   - mine_map equals a golden model stepping the same LFSR from 16'hACE1.
3. safe_en=1:
   - safe (0,0) -> bits 0,1,8,9 clear.
   - safe (3,3) -> bits 18-20, 26-28, 34-36 clear; still 10 mines.
   - Repeat over 50 seeds.
4. COLS=9, ROWS=9, NUM_MINES=72, safe (4,4):
   - exactly 72 mines, no bit >=81 set, all 9 safe bits clear.
   - Includes out-of-range rejection (cols 9-15).
5. seed_load with seed=0 -> lfsr=1. Two runs from seed 16'h1234 with identical start timing -> identical mine_map (determinism).
6. Reset and watchdog:
   - Reset at DRAW cycle 3 -> next cycle mine_map=0, busy=0, no done.
   - MAX_DRAWS=4, NUM_MINES=10 -> error=1, done pulse, mine_count<=4.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared definitions for the mine placer: width helper, default LFSR
// constants and the placement state encoding.
package mine_pkg;

  // Ceiling log2 for sizing counters and index fields at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Maximal-length Galois mask and default non-zero seed for a 16-bit LFSR.
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mine_lfsr.sv
// Free-running Galois LFSR with a synchronous seed load. A zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module mine_lfsr
  import mine_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next state: seed load wins over the normal Galois advance.
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end
  end

  // State register; advances every cycle regardless of the placer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mine_placer.sv
// Places NUM_MINES distinct mines on a COLS x ROWS board. One candidate
// cell per cycle is taken from the LFSR; candidates off the board, already
// mined, or inside the optional 3x3 first-click safe zone are rejected.
module mine_placer
  import mine_pkg::*;
#(
  parameter int                COLS      = 8,
  parameter int                ROWS      = 8,
  parameter int                NUM_MINES = 10,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
  parameter int                MAX_DRAWS = 4096,
  localparam int               CW        = clog2(COLS),
  localparam int               RW        = clog2(ROWS),
  localparam int               NCELL     = COLS * ROWS,
  localparam int               MCW       = clog2(NCELL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              safe_en,
  input  logic [RW-1:0]     safe_row,
  input  logic [CW-1:0]     safe_col,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [NCELL-1:0]  mine_map,
  output logic [MCW-1:0]    mine_count
);

  localparam int IW  = clog2(NCELL);
  localparam int DCW = clog2(MAX_DRAWS + 1);

  state_t           state_q;
  logic [NCELL-1:0] mine_map_q;
  logic [MCW-1:0]   mine_count_q;
  logic [DCW-1:0]   draw_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             safe_en_q;
  logic [RW-1:0]    safe_row_q;
  logic [CW-1:0]    safe_col_q;

  logic [LFSR_W-1:0] lfsr;

  mine_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed      (seed),
    .q         (lfsr)
  );

  // Candidate cell decoded straight from the low LFSR bits.
  logic [CW-1:0]    cand_col;
  logic [RW-1:0]    cand_row;
  logic [IW-1:0]    cand_idx;
  logic [NCELL-1:0] cand_bit;
  logic             in_range;
  logic             occupied;
  logic [RW-1:0]    row_dist;
  logic [CW-1:0]    col_dist;
  logic             in_safe;
  logic             accept;
  logic [MCW-1:0]   count_next;
  logic             last_draw;
  logic             unused_lfsr_hi;

  assign cand_col = lfsr[CW-1:0];
  assign cand_row = lfsr[CW+RW-1:CW];
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:CW+RW];

  // Decoded fields are a power of two wide, so columns/rows past the board
  // edge can appear and must be filtered before they alias onto a cell.
  assign in_range = ({1'b0, cand_col} < (CW+1)'(COLS)) &&
                    ({1'b0, cand_row} < (RW+1)'(ROWS));
  assign cand_idx = IW'(cand_row) * IW'(COLS) + IW'(cand_col);
  assign cand_bit = NCELL'(1) << cand_idx;
  assign occupied = |(mine_map_q & cand_bit);

  // Chebyshev distance <= 1 gives the 3x3 zone; edge clipping falls out
  // naturally because off-board cells are never candidates anyway.
  assign row_dist = (cand_row >= safe_row_q) ? (cand_row - safe_row_q)
                                              : (safe_row_q - cand_row);
  assign col_dist = (cand_col >= safe_col_q) ? (cand_col - safe_col_q)
                                              : (safe_col_q - cand_col);
  assign in_safe  = safe_en_q && (row_dist <= RW'(1)) && (col_dist <= CW'(1));

  assign accept     = in_range && !occupied && !in_safe;
  assign count_next = mine_count_q + MCW'(1);
  assign last_draw  = (draw_cnt_q + DCW'(1)) == DCW'(MAX_DRAWS);

  // Placement FSM with registered status outputs and board state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mine_map_q   <= '0;
      mine_count_q <= '0;
      draw_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      safe_en_q    <= 1'b0;
      safe_row_q   <= '0;
      safe_col_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mine_map_q   <= '0;
            mine_count_q <= '0;
            draw_cnt_q   <= '0;
            error_q      <= 1'b0;
            safe_en_q    <= safe_en;
            safe_row_q   <= safe_row;
            safe_col_q   <= safe_col;
            busy_q       <= 1'b1;
            state_q      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (mine_count_q == MCW'(NUM_MINES)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            draw_cnt_q <= draw_cnt_q + DCW'(1);
            if (accept) begin
              mine_map_q   <= mine_map_q | cand_bit;
              mine_count_q <= count_next;
            end
            // Completing the board takes priority over the watchdog.
            if (accept && (count_next == MCW'(NUM_MINES))) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (last_draw) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign mine_map   = mine_map_q;
  assign mine_count = mine_count_q;

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: default 8x8 board, a 9x9 fully packed
// board, and a tiny-watchdog instance, checked against a reference model.
module tb_mine_placer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (8x8, 10 mines)
  logic        ra, sta, sla, sea;
  logic [15:0] seeda;
  logic [2:0]  srowa, scola;
  logic        busya, donea, erra;
  logic [63:0] mapa;
  logic [6:0]  cnta;

  // Instance B: 9x9, 72 mines
  logic        rb, stb, slb, seb;
  logic [15:0] seedb;
  logic [3:0]  srowb, scolb;
  logic        busyb, doneb, errb;
  logic [80:0] mapb;
  logic [6:0]  cntb;

  // Instance C: 8x8, 10 mines, watchdog of 4 draws
  logic        rc, stc, slc, sec;
  logic [15:0] seedc;
  logic [2:0]  srowc, scolc;
  logic        busyc, donec, errc;
  logic [63:0] mapc;
  logic [6:0]  cntc;

  logic [2:0] done_v;
  assign done_v = {donec, doneb, donea};

  mine_placer u_a (
    .clk(clk), .reset(ra), .start(sta), .seed_load(sla), .seed(seeda),
    .safe_en(sea), .safe_row(srowa), .safe_col(scola),
    .busy(busya), .done(donea), .error(erra), .mine_map(mapa), .mine_count(cnta)
  );

  mine_placer #(.COLS(9), .ROWS(9), .NUM_MINES(72)) u_b (
    .clk(clk), .reset(rb), .start(stb), .seed_load(slb), .seed(seedb),
    .safe_en(seb), .safe_row(srowb), .safe_col(scolb),
    .busy(busyb), .done(doneb), .error(errb), .mine_map(mapb), .mine_count(cntb)
  );

  mine_placer #(.MAX_DRAWS(4)) u_c (
    .clk(clk), .reset(rc), .start(stc), .seed_load(slc), .seed(seedc),
    .safe_en(sec), .safe_row(srowc), .safe_col(scolc),
    .busy(busyc), .done(donec), .error(errc), .mine_map(mapc), .mine_count(cntc)
  );

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Shadow of instance A's LFSR, following the documented update rule.
  logic [15:0] sha;
  always @(posedge clk) begin
    if (ra) sha <= 16'hACE1;
    else if (sla) sha <= (seeda == 16'h0) ? 16'h0001 : seeda;
    else sha <= step(sha);
  end

  // Reference placement: one candidate per draw from successive LFSR states.
  function automatic void model(input logic [15:0] l0, input int cols, input int rows,
                                input int cw, input int rw, input int num, input int maxd,
                                input bit se, input int sr, input int sc,
                                output logic [127:0] map, output int cnt, output bit err);
    logic [15:0] l;
    int c, r, dr, dc;
    l = l0; map = '0; cnt = 0; err = 1'b0;
    if (num == 0) return;
    for (int d = 1; d <= maxd; d++) begin
      c = int'(l) & ((1 << cw) - 1);
      r = (int'(l) >> cw) & ((1 << rw) - 1);
      dr = (r > sr) ? r - sr : sr - r;
      dc = (c > sc) ? c - sc : sc - c;
      if (c < cols && r < rows && !map[r*cols+c] && !(se && dr <= 1 && dc <= 1)) begin
        map[r*cols+c] = 1'b1;
        cnt++;
        if (cnt == num) return;
      end
      if (d == maxd) err = 1'b1;
      else l = step(l);
    end
  endfunction

  function automatic logic [127:0] safe_mask(input int cols, input int rows, input int sr, input int sc);
    logic [127:0] m;
    m = '0;
    for (int r = sr - 1; r <= sr + 1; r++)
      for (int c = sc - 1; c <= sc + 1; c++)
        if (r >= 0 && r < rows && c >= 0 && c < cols) m[r*cols+c] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input int which, input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_v[which]) begin
        seen = 1'b1;
        cyc = i;
        break;
      end
    end
    chk("done_within_budget", 128'(seen), 128'd1);
  endtask

  task automatic run_a(input logic [15:0] sd, input bit use_seed, input bit force_l0,
                       input logic [15:0] l0f, input bit se, input int sr, input int sc,
                       input string tag, output logic [63:0] map_out);
    logic [15:0]  l0;
    logic [127:0] emap;
    int           ecnt, cyc;
    bit           eerr, seen;
    @(negedge clk);
    sta = 1'b1; sla = use_seed; seeda = sd; sea = se;
    srowa = 3'(sr); scola = 3'(sc);
    @(negedge clk);
    sta = 1'b0; sla = 1'b0;
    chk({tag, "_busy_start"}, 128'(busya), 128'd1);
    l0 = force_l0 ? l0f : sha;
    model(l0, 8, 8, 3, 3, 10, 4096, se, sr, sc, emap, ecnt, eerr);
    wait_done(0, 4200, cyc, seen);
    chk({tag, "_map"}, 128'(mapa), emap & 128'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_count"}, 128'(cnta), 128'(ecnt));
    chk({tag, "_error"}, 128'(erra), 128'(eerr));
    chk({tag, "_busy_done"}, 128'(busya), 128'd0);
    map_out = mapa;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 128'(donea), 128'd0);
  endtask

  initial begin
    logic [63:0]  m1, m2, mtmp;
    logic [127:0] emap;
    int           ecnt, cyc, sr, sc;
    bit           eerr, seen;

    ra = 1; rb = 1; rc = 1;
    sta = 0; sla = 0; sea = 0; seeda = '0; srowa = '0; scola = '0;
    stb = 0; slb = 0; seb = 0; seedb = '0; srowb = '0; scolb = '0;
    stc = 0; slc = 0; sec = 0; seedc = '0; srowc = '0; scolc = '0;

    // 1: reset and idle hold
    @(negedge clk); @(negedge clk);
    chk("rst_map", 128'(mapa), 128'd0);
    chk("rst_count", 128'(cnta), 128'd0);
    chk("rst_busy", 128'(busya), 128'd0);
    chk("rst_done", 128'(donea), 128'd0);
    chk("rst_error", 128'(erra), 128'd0);
    chk("rst_map_b", 128'(mapb), 128'd0);
    ra = 0; rb = 0; rc = 0;
    repeat (20) @(negedge clk);
    chk("idle_map", 128'(mapa), 128'd0);
    chk("idle_count", 128'(cnta), 128'd0);
    chk("idle_busy", 128'(busya), 128'd0);
    chk("idle_done", 128'(donea), 128'd0);

    // 2: default run from the reset seed, no safe zone
    run_a(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 0, "dflt", m1);
    chk("dflt_popcount", 128'($countones(m1)), 128'd10);
    chk("dflt_count10", 128'(cnta), 128'd10);

    // 3: safe zones
    run_a(16'h5A5A, 1'b1, 1'b0, 16'h0, 1'b1, 0, 0, "safe00", m1);
    chk("safe00_clear", 128'(m1 & 64'h0000_0000_0000_0303), 128'd0);
    run_a(16'h1357, 1'b1, 1'b0, 16'h0, 1'b1, 3, 3, "safe33", m1);
    chk("safe33_clear", 128'(m1 & 64'h0000_001C_1C1C_0000), 128'd0);
    chk("safe33_pop", 128'($countones(m1)), 128'd10);
    for (int k = 1; k <= 50; k++) begin
      sr = k % 8;
      sc = (k * 3) % 8;
      run_a(16'(k * 16'h0513 + 16'h0007), 1'b1, 1'b0, 16'h0, 1'b1, sr, sc, "sweep", m1);
      chk("sweep_clear", 128'(m1) & safe_mask(8, 8, sr, sc), 128'd0);
      chk("sweep_pop", 128'($countones(m1)), 128'd10);
    end

    // 5: zero-seed guard and determinism
    run_a(16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 0, 0, "seed0", m1);
    chk("seed0_first_mine", 128'(m1[1]), 128'd1);
    run_a(16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, "det1", m1);
    run_a(16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, "det2", m2);
    chk("determinism", 128'(m2), 128'(m1));

    // 6a: reset in the third DRAW cycle aborts without a done pulse
    @(negedge clk);
    sta = 1; sla = 1; seeda = 16'h1234; sea = 0;
    @(negedge clk);
    sta = 0; sla = 0;
    @(negedge clk); @(negedge clk);
    ra = 1;
    @(negedge clk);
    ra = 0;
    chk("abort_map", 128'(mapa), 128'd0);
    chk("abort_count", 128'(cnta), 128'd0);
    chk("abort_busy", 128'(busya), 128'd0);
    chk("abort_done", 128'(donea), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (donea) seen = 1'b1;
    end
    chk("abort_no_done", 128'(seen), 128'd0);
    run_a(16'h2468, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, "after_abort", mtmp);

    // 4: 9x9 board packed to 72 mines around safe cell (4,4)
    @(negedge clk);
    stb = 1; slb = 1; seedb = 16'hBEEF; seb = 1; srowb = 4'd4; scolb = 4'd4;
    @(negedge clk);
    stb = 0; slb = 0;
    chk("b_busy_start", 128'(busyb), 128'd1);
    model(16'hBEEF, 9, 9, 4, 4, 72, 4096, 1'b1, 4, 4, emap, ecnt, eerr);
    repeat (5) @(negedge clk);
    stb = 1;
    @(negedge clk);
    stb = 0;
    wait_done(1, 5000, cyc, seen);
    chk("b_map", 128'(mapb), emap);
    chk("b_count72", 128'(cntb), 128'd72);
    chk("b_popcount", 128'($countones(mapb)), 128'd72);
    chk("b_safe_clear", 128'(mapb) & safe_mask(9, 9, 4, 4), 128'd0);
    chk("b_error", 128'(errb), 128'd0);

    // 6b: watchdog with MAX_DRAWS=4
    @(negedge clk);
    stc = 1; slc = 1; seedc = 16'hACE1; sec = 0;
    @(negedge clk);
    stc = 0; slc = 0;
    model(16'hACE1, 8, 8, 3, 3, 10, 4, 1'b0, 0, 0, emap, ecnt, eerr);
    wait_done(2, 20, cyc, seen);
    chk("wd_latency", 128'(cyc), 128'd3);
    chk("wd_error", 128'(errc), 128'd1);
    chk("wd_count_le4", 128'(cntc <= 7'd4), 128'd1);
    chk("wd_map", 128'(mapc), emap & 128'hFFFF_FFFF_FFFF_FFFF);
    chk("wd_count", 128'(cntc), 128'(ecnt));
    @(negedge clk);
    chk("wd_done_pulse", 128'(donec), 128'd0);
    chk("wd_error_sticky", 128'(errc), 128'd1);
    stc = 1;
    @(negedge clk);
    stc = 0;
    chk("wd_error_cleared", 128'(errc), 128'd0);
    wait_done(2, 20, cyc, seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
